// File: rtl/regfile_fwd_sb_pkg.sv
// ---------------------------------------------------------------------------
// regfile_fwd_sb_pkg
//   Shared definitions for the ID-stage register file slice: default widths,
//   the architectural zero register/word and the operand-source encoding used
//   by the per-port read mux.
// ---------------------------------------------------------------------------
package regfile_fwd_sb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NUM_RD_DEF = 2;
  localparam int CNT_W_DEF  = 32;

  localparam logic [ADDR_W_DEF-1:0] REG_ZERO  = 5'd0;
  localparam logic [DATA_W_DEF-1:0] ZERO_WORD = 32'd0;

  // Where a read port takes its operand from. SRC_HOLD means the operand is
  // not available yet: the port returns zero and requests a stall.
  typedef enum logic [2:0] {
    SRC_ZERO  = 3'd0,
    SRC_EX    = 3'd1,
    SRC_MEM   = 3'd2,
    SRC_HOLD  = 3'd3,
    SRC_WB    = 3'd4,
    SRC_ARRAY = 3'd5
  } rd_src_e;

endpackage

// File: rtl/regfile_fwd_sb_if.sv
// ---------------------------------------------------------------------------
// regfile_fwd_sb_if
//   Bundles the pipeline-facing signals of the register file:
//     wb_*   write-back port (wb_long retires a long-latency op)
//     rd_*   NUM_RD read ports, rd_addr/rd_data packed port-major
//     ex_*   EX-stage forwarding source
//     mem_*  MEM-stage forwarding source
//     iss_*  ID issue info for the busy scoreboard
//     flush  clears the scoreboard
//     stall / stall_cnt  hazard output and perf counter
//   master = pipeline side (drives requests), slave = register file.
// ---------------------------------------------------------------------------
interface regfile_fwd_sb_if
  import regfile_fwd_sb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = NUM_RD_DEF,
  parameter int CNT_W  = CNT_W_DEF
);

  logic                     wb_en;
  logic [ADDR_W-1:0]        wb_addr;
  logic [DATA_W-1:0]        wb_data;
  logic                     wb_long;
  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic                     ex_we;
  logic [ADDR_W-1:0]        ex_dest;
  logic                     ex_rdy;
  logic [DATA_W-1:0]        ex_data;
  logic                     mem_we;
  logic [ADDR_W-1:0]        mem_dest;
  logic                     mem_rdy;
  logic [DATA_W-1:0]        mem_data;
  logic                     iss_en;
  logic                     iss_long;
  logic [ADDR_W-1:0]        iss_dest;
  logic                     flush;
  logic                     stall;
  logic [CNT_W-1:0]         stall_cnt;

  modport master (
    output wb_en, wb_addr, wb_data, wb_long,
    output rd_en, rd_addr,
    output ex_we, ex_dest, ex_rdy, ex_data,
    output mem_we, mem_dest, mem_rdy, mem_data,
    output iss_en, iss_long, iss_dest, flush,
    input  rd_data, stall, stall_cnt
  );

  modport slave (
    input  wb_en, wb_addr, wb_data, wb_long,
    input  rd_en, rd_addr,
    input  ex_we, ex_dest, ex_rdy, ex_data,
    input  mem_we, mem_dest, mem_rdy, mem_data,
    input  iss_en, iss_long, iss_dest, flush,
    output rd_data, stall, stall_cnt
  );

endinterface

// File: rtl/regfile_fwd_sb_rd_port.sv
// ---------------------------------------------------------------------------
// regfile_rd_port
//   One operand read port: priority mux over EX forward, MEM forward,
//   scoreboard busy, same-cycle WB bypass and the register array, plus the
//   port's stall request.
//   Ports: en/addr (request), ex_*/mem_* (forward sources), busy (scoreboard),
//          wb_* (write-back bypass), arr_data (array value at addr),
//          data/stall (combinational result).
// ---------------------------------------------------------------------------
module regfile_rd_port
  import regfile_fwd_sb_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_REGS = 2**ADDR_W
) (
  input  logic                en,
  input  logic [ADDR_W-1:0]   addr,
  input  logic                ex_we,
  input  logic [ADDR_W-1:0]   ex_dest,
  input  logic                ex_rdy,
  input  logic [DATA_W-1:0]   ex_data,
  input  logic                mem_we,
  input  logic [ADDR_W-1:0]   mem_dest,
  input  logic                mem_rdy,
  input  logic [DATA_W-1:0]   mem_data,
  input  logic [NUM_REGS-1:0] busy,
  input  logic                wb_en,
  input  logic                wb_long,
  input  logic [ADDR_W-1:0]   wb_addr,
  input  logic [DATA_W-1:0]   wb_data,
  input  logic [DATA_W-1:0]   arr_data,
  output logic [DATA_W-1:0]   data,
  output logic                stall
);

  rd_src_e src_s;
  logic    wb_clears_s;

  // A long-latency write-back retiring this very register releases the busy
  // bit in the same cycle, so the operand is taken from the WB bypass.
  assign wb_clears_s = wb_en && wb_long && (wb_addr == addr);

  // Source selection, first match wins; the younger EX result shadows MEM.
  always_comb begin
    src_s = SRC_ARRAY;
    if (!en || (addr == {ADDR_W{1'b0}})) begin
      src_s = SRC_ZERO;
    end else if (ex_we && (addr == ex_dest)) begin
      src_s = ex_rdy ? SRC_EX : SRC_HOLD;
    end else if (mem_we && (addr == mem_dest)) begin
      src_s = mem_rdy ? SRC_MEM : SRC_HOLD;
    end else if (busy[addr] && !wb_clears_s) begin
      src_s = SRC_HOLD;
    end else if (wb_en && (addr == wb_addr)) begin
      src_s = SRC_WB;
    end else begin
      src_s = SRC_ARRAY;
    end
  end

  // Operand and stall for the selected source.
  always_comb begin
    data  = {DATA_W{1'b0}};
    stall = 1'b0;
    case (src_s)
      SRC_ZERO:  begin data = {DATA_W{1'b0}}; stall = 1'b0; end
      SRC_EX:    begin data = ex_data;        stall = 1'b0; end
      SRC_MEM:   begin data = mem_data;       stall = 1'b0; end
      SRC_HOLD:  begin data = {DATA_W{1'b0}}; stall = 1'b1; end
      SRC_WB:    begin data = wb_data;        stall = 1'b0; end
      SRC_ARRAY: begin data = arr_data;       stall = 1'b0; end
      default:   begin data = {DATA_W{1'b0}}; stall = 1'b0; end
    endcase
  end

endmodule

// File: rtl/regfile_fwd_sb.sv
// ---------------------------------------------------------------------------
// regfile_fwd_sb
//   ID-stage integer register file with EX/MEM forwarding, WB bypass, a
//   busy scoreboard for long-latency writers and a stall-cycle counter.
//   Ports: clk, rst (synchronous, active-high), bus (regfile_fwd_sb_if.slave).
//   rd_data and stall are combinational; array, busy and stall_cnt update on
//   the rising clock edge. While rst is high, rd_data and stall read as zero.
// ---------------------------------------------------------------------------
module regfile_fwd_sb
  import regfile_fwd_sb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = NUM_RD_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input logic              clk,
  input logic              rst,
  regfile_fwd_sb_if.slave  bus
);

  localparam int NUM_REGS = 2**ADDR_W;

  logic [DATA_W-1:0]   regs_r [NUM_REGS];
  logic [NUM_REGS-1:0] busy_r;
  logic [NUM_REGS-1:0] busy_nxt_s;
  logic [DATA_W-1:0]   port_data_s [NUM_RD];
  logic [NUM_RD-1:0]   port_stall_s;
  logic                stall_s;
  logic [CNT_W-1:0]    stall_cnt_r;
  logic                iss_set_s;
  logic                wb_clr_s;

  genvar p;
  generate
    for (p = 0; p < NUM_RD; p++) begin : g_port
      logic [ADDR_W-1:0] addr_s;
      assign addr_s = bus.rd_addr[p*ADDR_W +: ADDR_W];

      regfile_rd_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
      ) u_port (
        .en       (bus.rd_en[p]),
        .addr     (addr_s),
        .ex_we    (bus.ex_we),
        .ex_dest  (bus.ex_dest),
        .ex_rdy   (bus.ex_rdy),
        .ex_data  (bus.ex_data),
        .mem_we   (bus.mem_we),
        .mem_dest (bus.mem_dest),
        .mem_rdy  (bus.mem_rdy),
        .mem_data (bus.mem_data),
        .busy     (busy_r),
        .wb_en    (bus.wb_en),
        .wb_long  (bus.wb_long),
        .wb_addr  (bus.wb_addr),
        .wb_data  (bus.wb_data),
        .arr_data (regs_r[addr_s]),
        .data     (port_data_s[p]),
        .stall    (port_stall_s[p])
      );
    end
  endgenerate

  // Combined stall, forced low during reset.
  always_comb begin
    if (rst) begin
      stall_s = 1'b0;
    end else begin
      stall_s = |port_stall_s;
    end
  end

  // Pack the per-port operands onto the bus, forced to zero during reset.
  always_comb begin
    bus.rd_data = {(NUM_RD*DATA_W){1'b0}};
    for (int i = 0; i < NUM_RD; i++) begin
      if (rst) begin
        bus.rd_data[i*DATA_W +: DATA_W] = {DATA_W{1'b0}};
      end else begin
        bus.rd_data[i*DATA_W +: DATA_W] = port_data_s[i];
      end
    end
  end

  assign bus.stall     = stall_s;
  assign bus.stall_cnt = stall_cnt_r;

  // Register array write; register 0 is never written so it always reads 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (bus.wb_en && (bus.wb_addr != {ADDR_W{1'b0}})) begin
      regs_r[bus.wb_addr] <= bus.wb_data;
    end else begin
      regs_r <= regs_r;
    end
  end

  // A new long-latency issue is only accepted when ID is not stalled.
  assign iss_set_s = bus.iss_en && bus.iss_long && !stall_s &&
                     (bus.iss_dest != {ADDR_W{1'b0}});
  assign wb_clr_s  = bus.wb_en && bus.wb_long;

  // Scoreboard next state: clear first, then set so a freshly issued writer
  // wins over a retiring one on the same register; flush overrides both.
  always_comb begin
    busy_nxt_s = busy_r;
    if (bus.flush) begin
      busy_nxt_s = {NUM_REGS{1'b0}};
    end else begin
      if (wb_clr_s) begin
        busy_nxt_s[bus.wb_addr] = 1'b0;
      end else begin
        busy_nxt_s = busy_nxt_s;
      end
      if (iss_set_s) begin
        busy_nxt_s[bus.iss_dest] = 1'b1;
      end else begin
        busy_nxt_s = busy_nxt_s;
      end
    end
    busy_nxt_s[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= {NUM_REGS{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

endmodule
